fetch_stage: RTL and testbench

Instruction-fetch front end of the five-stage MIPS pipeline. Holds the program counter that addresses instruction memory, computes the next fetch address from decode-stage branch/jump information, and registers each fetched word with its PC into the IF/ID pipeline register. Sits between the hazard/decode logic (which drive stall, redirect select and the `jr` operand) and the decode stage (which consumes `d_instr`, `d_pc` and `d_pc8`). Branches have one architectural delay slot: no flush.

---
 rtl/fetch_stage_pkg.sv | 11 +
 rtl/fetch_stage_next_pc.sv | 27 ++
 rtl/fetch_stage.sv | 49 ++++
 tb/tb_fetch_stage.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared encodings and constants for the instruction-fetch stage
package fetch_stage_pkg;
  typedef enum logic [1:0] {
    NPC_PC4 = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP = 32'h0;
endpackage

// File: rtl/fetch_stage_next_pc.sv
// next_pc_calc: combinational next fetch address from decode-stage branch/jump info
module next_pc_calc
  import fetch_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_instr,
  input  logic [1:0]  npc_sel,
  input  logic        branch_taken,
  input  logic [31:0] jr_target,
  output logic [31:0] npc
);
  logic [31:0] pc4;
  logic [31:0] dpc4;
  logic [31:0] br;
  logic [31:0] jmp;
  // branch offset is relative to the delay slot, jump region comes from the delay slot too
  always_comb begin
    pc4  = pc + 32'd4;
    dpc4 = d_pc + 32'd4;
    br   = dpc4 + {{14{d_instr[15]}}, d_instr[15:0], 2'b00};
    jmp  = {dpc4[31:28], d_instr[25:0], 2'b00};
    npc  = npc_sel == NPC_JR ? jr_target :
           npc_sel == NPC_J ? jmp :
           (npc_sel == NPC_BR && branch_taken) ? br : pc4;
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, IF/ID register and fetch-address check of the MIPS front end
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        branch_taken,
  input  logic [31:0] jr_target,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8,
  output logic        d_pc_err
);
  localparam logic [31:0] PC_LAST = RESET_PC + 32'(IM_WORDS) * 32'd4 - 32'd1;
  logic [31:0] npc;
  logic        err;
  next_pc_calc u_npc (
    .pc(pc),
    .d_pc(d_pc),
    .d_instr(d_instr),
    .npc_sel(npc_sel),
    .branch_taken(branch_taken),
    .jr_target(jr_target),
    .npc(npc)
  );
  assign err   = (pc[1:0] != 2'b00) || (pc < RESET_PC) || (pc > PC_LAST);
  assign d_pc8 = d_pc + 32'd8;
  // reset wins, stall freezes everything, otherwise advance PC and load IF/ID (nop on bad fetch)
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      d_instr  <= NOP;
      d_pc     <= '0;
      d_pc_err <= 1'b0;
    end else if (!stall) begin
      pc       <= npc;
      d_instr  <= err ? NOP : instr_in;
      d_pc     <= pc;
      d_pc_err <= err;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic        branch_taken = 1'b0;
  logic [31:0] jr_target = 32'h0;
  logic [31:0] instr_in = 32'h0;
  logic [31:0] pc;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] d_pc8;
  logic        d_pc_err;
  int          n_cmp = 0;
  int          n_bad = 0;

  fetch_stage dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .npc_sel(npc_sel),
    .branch_taken(branch_taken),
    .jr_target(jr_target),
    .instr_in(instr_in),
    .pc(pc),
    .d_instr(d_instr),
    .d_pc(d_pc),
    .d_pc8(d_pc8),
    .d_pc_err(d_pc_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic [31:0] e_pc, input logic [31:0] e_dpc,
                        input logic [31:0] e_ins, input logic e_err);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".d_pc"}, d_pc, e_dpc);
    chk({tag, ".d_instr"}, d_instr, e_ins);
    chk({tag, ".d_pc_err"}, {31'b0, d_pc_err}, {31'b0, e_err});
  endtask

  initial begin
    step();
    step();
    chk_if("reset", 32'h3000, 32'h0, 32'h0, 1'b0);
    chk("reset.d_pc8", d_pc8, 32'h8);

    reset = 1'b0;
    instr_in = 32'h1111_0000;
    step();
    chk_if("seq1", 32'h3004, 32'h3000, 32'h1111_0000, 1'b0);
    instr_in = 32'h1000_FFFF;
    step();
    chk_if("seq2", 32'h3008, 32'h3004, 32'h1000_FFFF, 1'b0);
    chk("seq2.d_pc8", d_pc8, 32'h300C);
    npc_sel = 2'b01;
    branch_taken = 1'b0;
    instr_in = 32'h2222_3008;
    step();
    chk_if("beq_nt", 32'h300C, 32'h3008, 32'h2222_3008, 1'b0);
    chk("beq_nt.d_pc8", d_pc8, 32'h3010);

    branch_taken = 1'b1;
    reset = 1'b1;
    step();
    chk_if("rst_redirect", 32'h3000, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;
    npc_sel = 2'b00;
    branch_taken = 1'b0;
    instr_in = 32'h1111_0000;
    step();
    instr_in = 32'h1000_FFFF;
    step();
    npc_sel = 2'b01;
    branch_taken = 1'b1;
    instr_in = 32'h2222_3008;
    step();
    chk_if("beq_t", 32'h3004, 32'h3008, 32'h2222_3008, 1'b0);
    npc_sel = 2'b00;
    branch_taken = 1'b0;
    instr_in = 32'h1000_FFFF;
    step();
    chk_if("beq_tgt", 32'h3008, 32'h3004, 32'h1000_FFFF, 1'b0);

    reset = 1'b1;
    step();
    reset = 1'b0;
    instr_in = 32'h0C00_0C10;
    step();
    chk_if("jal_dec", 32'h3004, 32'h3000, 32'h0C00_0C10, 1'b0);
    chk("jal_dec.d_pc8", d_pc8, 32'h3008);
    npc_sel = 2'b10;
    instr_in = 32'h3333_3004;
    step();
    chk_if("jal", 32'h3040, 32'h3004, 32'h3333_3004, 1'b0);

    stall = 1'b1;
    npc_sel = 2'b11;
    jr_target = 32'h3100;
    instr_in = 32'h4444_3040;
    step();
    chk_if("stall1", 32'h3040, 32'h3004, 32'h3333_3004, 1'b0);
    step();
    chk_if("stall2", 32'h3040, 32'h3004, 32'h3333_3004, 1'b0);
    stall = 1'b0;
    step();
    chk_if("jr", 32'h3100, 32'h3040, 32'h4444_3040, 1'b0);

    jr_target = 32'h3002;
    instr_in = 32'h5555_3100;
    step();
    chk_if("jr_misal", 32'h3002, 32'h3100, 32'h5555_3100, 1'b0);
    jr_target = 32'h7000;
    instr_in = 32'h6666_6666;
    step();
    chk_if("err_align", 32'h7000, 32'h3002, 32'h0, 1'b1);
    jr_target = 32'h3000;
    instr_in = 32'h7777_7777;
    step();
    chk_if("err_range", 32'h3000, 32'h7000, 32'h0, 1'b1);
    npc_sel = 2'b00;
    instr_in = 32'h1111_0000;
    step();
    chk_if("err_clear", 32'h3004, 32'h3000, 32'h1111_0000, 1'b0);

    npc_sel = 2'b11;
    jr_target = 32'h6FFC;
    instr_in = 32'h1000_FFFF;
    step();
    npc_sel = 2'b00;
    instr_in = 32'h8888_6FFC;
    step();
    chk_if("last_word", 32'h7000, 32'h6FFC, 32'h8888_6FFC, 1'b0);
    instr_in = 32'h9999_9999;
    step();
    chk_if("past_end", 32'h7004, 32'h7000, 32'h0, 1'b1);

    stall = 1'b1;
    reset = 1'b1;
    step();
    chk_if("rst_stall", 32'h3000, 32'h0, 32'h0, 1'b0);
    chk("rst_stall.d_pc8", d_pc8, 32'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
